// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the single-cycle ARM control unit: ALU controls,
// opcode classes, condition codes, DP command values and the condition evaluator.
package arm_ctrl_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10
    } op_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110
    } cond_e;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // flags = {N,Z,C,V}; 1111 and any unknown code never execute
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        {n, z, c, v} = flags;
        case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = ~z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = ~c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = ~n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = ~v;
            COND_HI: cond_pass = c & ~z;
            COND_LS: cond_pass = ~c | z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = ~z & (n == v);
            COND_LE: cond_pass = z | (n != v);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cond_logic.sv
// NZCV status register plus condition check; gates every architectural
// side effect (register write, memory write, PC load, flag update).
module cond_logic
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags
);

    logic [3:0] r_flags;
    logic       w_cond_ex;

    // Only the registered flags feed the check, so an update lands one instruction later
    assign w_cond_ex = cond_pass(Cond, r_flags);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= FLAG_RST;
        end else begin
            if (FlagW[1] & w_cond_ex)
                r_flags[3:2] <= ALUFlags[3:2];
            if (FlagW[0] & w_cond_ex)
                r_flags[1:0] <= ALUFlags[1:0];
        end
    end

    assign RegWrite = RegW & w_cond_ex & ~reset;
    assign MemWrite = MemW & w_cond_ex & ~reset;
    assign PCSrc    = PCS  & w_cond_ex & ~reset;
    assign Flags    = r_flags;

endmodule

// File: rtl/control_unit.sv
// Single-cycle ARM control unit: main decoder and ALU decoder over Instr[31:12],
// with condition evaluation and the flag register in cond_logic.
module control_unit
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAG_RST = 4'b0000,
    parameter bit         EN_CMP   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic [1:0]  ImmSrc,
    output logic        ALUSrc,
    output logic [1:0]  ALUControl,
    output logic        MemtoReg,
    output logic        MemWrite,
    output logic        PCSrc,
    output logic [3:0]  Flags
);

    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic [3:0] w_rd;
    logic [3:0] w_unused_rn;
    logic       w_regw_main, w_regw, w_memw, w_branch, w_alu_op, w_pcs;
    logic [1:0] w_flag_w;
    alu_ctrl_e  w_alu_ctrl;

    assign w_cond      = Instr[19:16];
    assign w_op        = Instr[15:14];
    assign w_funct     = Instr[13:8];
    assign w_unused_rn = Instr[7:4];
    assign w_rd        = Instr[3:0];

    always_comb begin
        RegSrc      = 2'b00;
        ImmSrc      = 2'b00;
        ALUSrc      = 1'b0;
        MemtoReg    = 1'b0;
        w_regw_main = 1'b0;
        w_memw      = 1'b0;
        w_branch    = 1'b0;
        w_alu_op    = 1'b0;
        case (w_op)
            OP_DP: begin
                ALUSrc      = w_funct[5];
                w_regw_main = 1'b1;
                w_alu_op    = 1'b1;
            end
            OP_MEM: begin
                ImmSrc = 2'b01;
                ALUSrc = 1'b1;
                if (w_funct[0]) begin
                    MemtoReg    = 1'b1;
                    w_regw_main = 1'b1;
                end else begin
                    RegSrc = 2'b10;
                    w_memw = 1'b1;
                end
            end
            OP_BR: begin
                RegSrc   = 2'b01;
                ImmSrc   = 2'b10;
                ALUSrc   = 1'b1;
                w_branch = 1'b1;
            end
            default: ;  // Op=11 and unknown Op: every enable stays 0
        endcase
    end

    // Unsupported DP commands fall through as a full no-op
    always_comb begin
        w_alu_ctrl = ALU_ADD;
        w_flag_w   = 2'b00;
        w_regw     = w_regw_main;
        if (w_alu_op) begin
            case (w_funct[4:1])
                CMD_ADD: begin w_alu_ctrl = ALU_ADD; w_flag_w = {2{w_funct[0]}}; end
                CMD_SUB: begin w_alu_ctrl = ALU_SUB; w_flag_w = {2{w_funct[0]}}; end
                CMD_AND: begin w_alu_ctrl = ALU_AND; w_flag_w = {w_funct[0], 1'b0}; end
                CMD_ORR: begin w_alu_ctrl = ALU_ORR; w_flag_w = {w_funct[0], 1'b0}; end
                CMD_CMP: begin
                    if (EN_CMP) begin
                        w_alu_ctrl = ALU_SUB;
                        w_flag_w   = 2'b11;
                    end
                    w_regw = 1'b0;
                end
                default: w_regw = 1'b0;
            endcase
        end
    end

    assign ALUControl = w_alu_ctrl;
    assign w_pcs      = w_branch | (w_regw & (w_rd == 4'hF));

    cond_logic #(
        .FLAG_RST (FLAG_RST)
    ) u_cond_logic (
        .clk      (clk),
        .reset    (reset),
        .Cond     (w_cond),
        .ALUFlags (ALUFlags),
        .FlagW    (w_flag_w),
        .PCS      (w_pcs),
        .RegW     (w_regw),
        .MemW     (w_memw),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .Flags    (Flags)
    );

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: decode per instruction class, flag latency,
// independent flag halves, CMP, no-ops and asynchronous reset mid-stream.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic [1:0]  RegSrc, ImmSrc, ALUControl;
    logic        RegWrite, ALUSrc, MemtoReg, MemWrite, PCSrc;
    logic [3:0]  Flags;

    int n_checks = 0;
    int n_fail   = 0;

    control_unit #(.FLAG_RST(4'b0000), .EN_CMP(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .RegSrc     (RegSrc),
        .RegWrite   (RegWrite),
        .ImmSrc     (ImmSrc),
        .ALUSrc     (ALUSrc),
        .ALUControl (ALUControl),
        .MemtoReg   (MemtoReg),
        .MemWrite   (MemWrite),
        .PCSrc      (PCSrc),
        .Flags      (Flags)
    );

    always #5 clk = ~clk;

    // Apply one instruction on the falling edge and let decode settle
    task automatic apply(input logic [19:0] ins, input logic [3:0] af, input string name);
        @(negedge clk);
        Instr    = ins;
        ALUFlags = af;
        #1;
        $display("txn %-10s instr=%05h aluflags=%04b -> regw=%b memw=%b pcsrc=%b aluctl=%02b flags=%04b",
                 name, ins, af, RegWrite, MemWrite, PCSrc, ALUControl, Flags);
    endtask

    task automatic clock_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; Instr = 20'hE1821; ALUFlags = 4'b1111;
        #1;
        n_checks++; if (Flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", Flags); end
        n_checks++; if ({RegWrite, MemWrite, PCSrc} !== 3'b000) begin n_fail++; $display("FAIL reset_enables got=%b exp=000", {RegWrite, MemWrite, PCSrc}); end
        n_checks++; if (ALUControl !== 2'b11) begin n_fail++; $display("FAIL reset_decode_alu got=%b exp=11", ALUControl); end
        clock_edge();
        n_checks++; if (Flags !== 4'b0000) begin n_fail++; $display("FAIL reset_hold_flags got=%b exp=0000", Flags); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_dp_orr();
        apply(20'hE1821, 4'b0000, "ORR_AL");
        n_checks++; if ({ALUControl, ALUSrc} !== 3'b110) begin n_fail++; $display("FAIL orr_alu got=%b exp=110", {ALUControl, ALUSrc}); end
        n_checks++; if ({RegWrite, MemWrite, PCSrc} !== 3'b100) begin n_fail++; $display("FAIL orr_enables got=%b exp=100", {RegWrite, MemWrite, PCSrc}); end
        n_checks++; if ({RegSrc, ImmSrc, MemtoReg} !== 5'b00000) begin n_fail++; $display("FAIL orr_srcs got=%b exp=00000", {RegSrc, ImmSrc, MemtoReg}); end
    endtask

    task automatic test_flag_latency();
        // Same-cycle ALUFlags Z=1 must not satisfy EQ while registered Z=0
        apply(20'h02844, 4'b0100, "ADDEQ_pre");
        n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL addeq_same_cycle got=%b exp=0", RegWrite); end
        apply(20'hE0500, 4'b0100, "SUBS");
        n_checks++; if ({ALUControl, RegWrite} !== 3'b011) begin n_fail++; $display("FAIL subs_decode got=%b exp=011", {ALUControl, RegWrite}); end
        clock_edge();
        n_checks++; if (Flags !== 4'b0100) begin n_fail++; $display("FAIL subs_flags got=%b exp=0100", Flags); end
        apply(20'h02844, 4'b0000, "ADDEQ");
        n_checks++; if ({RegWrite, ALUControl, ALUSrc} !== 4'b1001) begin n_fail++; $display("FAIL addeq got=%b exp=1001", {RegWrite, ALUControl, ALUSrc}); end
        apply(20'h12844, 4'b0000, "ADDNE");
        n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL addne got=%b exp=0", RegWrite); end
    endtask

    task automatic test_flag_halves();
        apply(20'hE0111, 4'b1011, "ANDS");
        n_checks++; if ({ALUControl, RegWrite} !== 3'b101) begin n_fail++; $display("FAIL ands_decode got=%b exp=101", {ALUControl, RegWrite}); end
        clock_edge();
        n_checks++; if (Flags !== 4'b1000) begin n_fail++; $display("FAIL ands_flags got=%b exp=1000", Flags); end
    endtask

    task automatic test_cmp();
        apply(20'hE1410, 4'b0011, "CMP_S0");
        n_checks++; if ({ALUControl, RegWrite, PCSrc} !== 4'b0100) begin n_fail++; $display("FAIL cmp_decode got=%b exp=0100", {ALUControl, RegWrite, PCSrc}); end
        clock_edge();
        n_checks++; if (Flags !== 4'b0011) begin n_fail++; $display("FAIL cmp_flags got=%b exp=0011", Flags); end
        // Flags now N=0 Z=0 C=1 V=1
        apply(20'hA1821, 4'b0000, "ORR_GE");
        n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL cond_ge got=%b exp=0", RegWrite); end
        apply(20'hB1821, 4'b0000, "ORR_LT");
        n_checks++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL cond_lt got=%b exp=1", RegWrite); end
        apply(20'h81821, 4'b0000, "ORR_HI");
        n_checks++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL cond_hi got=%b exp=1", RegWrite); end
        apply(20'h91821, 4'b0000, "ORR_LS");
        n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL cond_ls got=%b exp=0", RegWrite); end
    endtask

    task automatic test_mem();
        apply(20'hE5821, 4'b0000, "STR");
        n_checks++; if ({MemWrite, RegWrite, RegSrc, ImmSrc, ALUSrc} !== 7'b1010011) begin n_fail++; $display("FAIL str got=%b exp=1010011", {MemWrite, RegWrite, RegSrc, ImmSrc, ALUSrc}); end
        n_checks++; if (ALUControl !== 2'b00) begin n_fail++; $display("FAIL str_alu got=%b exp=00", ALUControl); end
        apply(20'hE5921, 4'b0000, "LDR");
        n_checks++; if ({MemtoReg, RegWrite, MemWrite, RegSrc, ImmSrc} !== 7'b1100001) begin n_fail++; $display("FAIL ldr got=%b exp=1100001", {MemtoReg, RegWrite, MemWrite, RegSrc, ImmSrc}); end
    endtask

    task automatic test_branch();
        apply(20'hEA000, 4'b0000, "B_AL");
        n_checks++; if ({PCSrc, ImmSrc, RegSrc, RegWrite, MemWrite} !== 7'b1100100) begin n_fail++; $display("FAIL b_al got=%b exp=1100100", {PCSrc, ImmSrc, RegSrc, RegWrite, MemWrite}); end
        apply(20'hFA000, 4'b0000, "B_NV");
        n_checks++; if (PCSrc !== 1'b0) begin n_fail++; $display("FAIL b_nv got=%b exp=0", PCSrc); end
        apply(20'hE080F, 4'b0000, "ADD_PC");
        n_checks++; if ({PCSrc, RegWrite} !== 2'b11) begin n_fail++; $display("FAIL add_pc got=%b exp=11", {PCSrc, RegWrite}); end
    endtask

    task automatic test_noop();
        apply(20'hEC000, 4'b1111, "OP11");
        n_checks++; if ({RegWrite, MemWrite, PCSrc} !== 3'b000) begin n_fail++; $display("FAIL op11_enables got=%b exp=000", {RegWrite, MemWrite, PCSrc}); end
        clock_edge();
        n_checks++; if (Flags !== 4'b0011) begin n_fail++; $display("FAIL op11_flags got=%b exp=0011", Flags); end
        apply(20'hE0311, 4'b1111, "EORS_unsup");
        n_checks++; if ({RegWrite, ALUControl} !== 3'b000) begin n_fail++; $display("FAIL unsup_decode got=%b exp=000", {RegWrite, ALUControl}); end
        clock_edge();
        n_checks++; if (Flags !== 4'b0011) begin n_fail++; $display("FAIL unsup_flags got=%b exp=0011", Flags); end
        apply(20'h00111, 4'b1111, "ANDSEQ_nx");
        clock_edge();
        n_checks++; if (Flags !== 4'b0011) begin n_fail++; $display("FAIL condfail_flags got=%b exp=0011", Flags); end
    endtask

    task automatic test_reset_mid();
        apply(20'hE0111, 4'b1111, "ANDS_rst");
        n_checks++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL pre_rst_regw got=%b exp=1", RegWrite); end
        #1 reset = 1'b1;
        #1;
        $display("txn %-10s reset asserted -> regw=%b flags=%04b", "RESET_MID", RegWrite, Flags);
        n_checks++; if (Flags !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_flags got=%b exp=0000", Flags); end
        n_checks++; if ({RegWrite, ALUControl} !== 3'b010) begin n_fail++; $display("FAIL mid_rst_outputs got=%b exp=010", {RegWrite, ALUControl}); end
        clock_edge();
        n_checks++; if (Flags !== 4'b0000) begin n_fail++; $display("FAIL rst_edge_flags got=%b exp=0000", Flags); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL post_rst_regw got=%b exp=1", RegWrite); end
        clock_edge();
        n_checks++; if (Flags !== 4'b1100) begin n_fail++; $display("FAIL post_rst_flags got=%b exp=1100", Flags); end
    endtask

    initial begin
        test_reset();
        test_dp_orr();
        test_flag_latency();
        test_flag_halves();
        test_cmp();
        test_mem();
        test_branch();
        test_noop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
